mem_access_stage: RTL

EX/MEM pipeline register plus load/store unit for the 5-stage RV32I core. It captures the EX-stage ALU result, store data and control, and drives a request/grant/response data-memory port. It byte-aligns store data, and extracts and sign- or zero-extends load data. It registers the write-back result into the WB stage and exports MEM-stage forwarding info to the EX forwarding/ALU-input logic.

---
 rtl/mem_access_stage.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and load/store unit: byte-lane store alignment, load extraction,
// WB register and MEM-stage forwarding. Optional misalignment trap via MEM_MISALIGN_CHECK_EN.
module mem_access_stage #(
  parameter int unsigned DMEM_AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [31:0]        ex_alu_result,
  input  logic [31:0]        ex_store_data,
  input  logic [2:0]         ex_funct3,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_reg_write,
  input  logic [4:0]         ex_rd_addr,
  output logic [31:0]        mem_fwd_data,
  output logic [4:0]         mem_fwd_rd,
  output logic               mem_fwd_reg_write,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_gnt,
  input  logic               dmem_rvalid,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid,
  output logic               wb_reg_write,
  output logic [4:0]         wb_rd_addr,
  output logic [31:0]        wb_data,
  output logic               misaligned
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [0:0] {IDLE, WAIT_RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_valid_m;
  logic [XLEN-1:0]   r_alu_m;
  logic [XLEN-1:0]   r_sdata_m;
  logic [2:0]        r_funct3_m;
  logic              r_mem_read_m;
  logic              r_mem_write_m;
  logic              r_reg_write_m;
  logic [4:0]        r_rd_m;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_byte;
  logic              w_is_half;
  logic [1:0]        w_a;
  logic              w_misal;
  logic              w_done;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;
  logic [XLEN-1:0]   w_ld_ext;

  assign w_a        = r_alu_m[1:0];
  assign w_is_load  = r_valid_m && r_mem_read_m;
  assign w_is_store = r_valid_m && r_mem_write_m && !r_mem_read_m;
  assign w_is_byte  = (r_funct3_m[1:0] == 2'b00);
  assign w_is_half  = (r_funct3_m[1:0] == 2'b01);

`ifdef MEM_MISALIGN_CHECK_EN
  assign w_misal = (w_is_load || w_is_store) &&
                   ((w_is_half && w_a[0]) || (!w_is_byte && !w_is_half && (w_a != 2'b00)));
`else
  assign w_misal = 1'b0;
`endif
  assign misaligned = w_misal;

  // MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_m     <= 1'b0;
      r_alu_m       <= '0;
      r_sdata_m     <= '0;
      r_funct3_m    <= '0;
      r_mem_read_m  <= 1'b0;
      r_mem_write_m <= 1'b0;
      r_reg_write_m <= 1'b0;
      r_rd_m        <= '0;
    end else if (ex_ready) begin
      r_valid_m <= ex_valid;
      if (ex_valid) begin
        r_alu_m       <= ex_alu_result;
        r_sdata_m     <= ex_store_data;
        r_funct3_m    <= ex_funct3;
        r_mem_read_m  <= ex_mem_read;
        r_mem_write_m <= ex_mem_write;
        r_reg_write_m <= ex_reg_write;
        r_rd_m        <= ex_rd_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request generation, completion and next state
  always_comb begin
    w_state_nxt = r_state;
    dmem_req    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        dmem_req = (w_is_load || w_is_store) && !w_misal;
        if (w_misal)                     w_done = 1'b1;
        else if (w_is_store)             w_done = dmem_gnt;
        else if (w_is_load)              w_done = 1'b0;
        else                             w_done = r_valid_m;
        if (dmem_req && dmem_gnt && w_is_load) w_state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        w_done = dmem_rvalid;
        if (dmem_rvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign ex_ready  = !r_valid_m || w_done;
  assign dmem_we   = w_is_store;
  assign dmem_addr = {r_alu_m[DMEM_AW-1:2], 2'b00};

  // Store lane alignment; halfword lane picks on a[1] only
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = r_sdata_m;
    if (w_is_byte) begin
      dmem_be    = 4'b0001 << w_a;
      dmem_wdata = {4{r_sdata_m[7:0]}};
    end else if (w_is_half) begin
      dmem_be    = w_a[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{r_sdata_m[15:0]}};
    end
  end

  // Load extraction and extension
  always_comb begin
    w_ld_byte = dmem_rdata[7:0];
    unique case (w_a)
      2'd0: w_ld_byte = dmem_rdata[7:0];
      2'd1: w_ld_byte = dmem_rdata[15:8];
      2'd2: w_ld_byte = dmem_rdata[23:16];
      2'd3: w_ld_byte = dmem_rdata[31:24];
      default: w_ld_byte = dmem_rdata[7:0];
    endcase
    w_ld_half = w_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    w_ld_ext  = dmem_rdata;
    if (w_is_byte)
      w_ld_ext = {{24{!r_funct3_m[2] && w_ld_byte[7]}}, w_ld_byte};
    else if (w_is_half)
      w_ld_ext = {{16{!r_funct3_m[2] && w_ld_half[15]}}, w_ld_half};
  end

  // WB register; a trapped access reports its address and never writes rd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd_addr   <= '0;
      wb_data      <= '0;
    end else if (w_done) begin
      wb_valid     <= 1'b1;
      wb_rd_addr   <= r_rd_m;
      wb_reg_write <= r_reg_write_m && (r_rd_m != 5'd0) && !w_misal;
      wb_data      <= (w_is_load && !w_misal) ? w_ld_ext : r_alu_m;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
    end
  end

  assign mem_fwd_data      = r_alu_m;
  assign mem_fwd_rd        = r_rd_m;
  assign mem_fwd_reg_write = r_valid_m && r_reg_write_m && !r_mem_read_m;

endmodule
